opm_window_monitor: RTL and testbench

//   Consumer of the per-cycle power estimate produced by an opm<N> power model.

---
 rtl/opm_window_monitor_pkg.sv | 18 +
 rtl/opm_window_monitor_if.sv | 26 ++
 rtl/opm_window_monitor_out_reg.sv | 83 ++++++++
 rtl/opm_window_monitor.sv | 116 +++++++++++
 tb/tb_opm_window_monitor.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/opm_window_monitor_pkg.sv
// Shared types and constants for the opm window monitor.
// The optional OPM_MON_PEAK_EN build adds per-window peak tracking.
package opm_window_monitor_pkg;

    localparam int unsigned DEF_IN_W    = 10;
    localparam int unsigned DEF_LOG_WIN = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } mon_state_e;

    // Sum width that cannot wrap over 2**log_win samples of in_w bits.
    function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned log_win);
        return in_w + log_win;
    endfunction

endpackage

// File: rtl/opm_window_monitor_if.sv
// Result port of the window monitor: valid/ready plus result payload.
interface opm_window_monitor_if
    import opm_window_monitor_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned ACC_W = acc_width(DEF_IN_W, DEF_LOG_WIN)
) ();

    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_sum;
    logic [IN_W-1:0]  res_avg;
    logic             res_alarm;
    logic [IN_W-1:0]  res_peak;

    modport master (
        output res_valid, res_sum, res_avg, res_alarm, res_peak,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_sum, res_avg, res_alarm, res_peak,
        output res_ready
    );

endinterface

// File: rtl/opm_window_monitor_out_reg.sv
// Result holding register with valid/ready handshake and sticky drop flag.
module opm_window_monitor_out_reg
    import opm_window_monitor_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned ACC_W = acc_width(DEF_IN_W, DEF_LOG_WIN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clr,
    input  logic [ACC_W-1:0]     sum,
    input  logic [IN_W-1:0]      avg,
    input  logic                 alarm,
    input  logic [IN_W-1:0]      peak,
    opm_window_monitor_if.master res_if,
    output logic                 ovf
);

    logic             valid_q, valid_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [IN_W-1:0]  avg_q, avg_d;
    logic             alarm_q, alarm_d;
    logic [IN_W-1:0]  peak_q, peak_d;
    logic             ovf_q, ovf_d;
    logic             busy_c;

    // Load, hold, drop or retire the result; a busy slot keeps the old result.
    always_comb begin
        valid_d = valid_q;
        sum_d   = sum_q;
        avg_d   = avg_q;
        alarm_d = alarm_q;
        peak_d  = peak_q;
        ovf_d   = ovf_q;
        busy_c  = valid_q && !res_if.res_ready;

        if (clr) begin
            ovf_d = 1'b0;
        end

        if (load) begin
            if (busy_c) begin
                ovf_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                sum_d   = sum;
                avg_d   = avg;
                alarm_d = alarm;
                peak_d  = peak;
            end
        end else if (valid_q && res_if.res_ready) begin
            valid_d = 1'b0;
        end
    end

    // Result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            avg_q   <= '0;
            alarm_q <= 1'b0;
            peak_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            avg_q   <= avg_d;
            alarm_q <= alarm_d;
            peak_q  <= peak_d;
            ovf_q   <= ovf_d;
        end
    end

    assign res_if.res_valid = valid_q;
    assign res_if.res_sum   = sum_q;
    assign res_if.res_avg   = avg_q;
    assign res_if.res_alarm = alarm_q;
    assign res_if.res_peak  = peak_q;
    assign ovf              = ovf_q;

endmodule

// File: rtl/opm_window_monitor.sv
// Windowed accumulator of opm power estimates: sum, average, alarm per window.
// Define OPM_MON_PEAK_EN to also report the per-window maximum on res_peak.
module opm_window_monitor
    import opm_window_monitor_pkg::*;
#(
    parameter int unsigned IN_W    = DEF_IN_W,
    parameter int unsigned LOG_WIN = DEF_LOG_WIN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [IN_W-1:0]      pwr_in,
    input  logic [IN_W-1:0]      thr,
    opm_window_monitor_if.master res_if,
    output logic                 ovf
);

    localparam int unsigned ACC_W = acc_width(IN_W, LOG_WIN);
    localparam logic [LOG_WIN-1:0] CNT_LAST = '1;

    mon_state_e         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LOG_WIN-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]   sum_c;
    logic [IN_W-1:0]    avg_c;
    logic               alarm_c;
    logic               last_c;
    logic               load_c;
    logic [IN_W-1:0]    peak_c;

    // Sample accumulation, window completion and FSM next state; clr wins over en.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_c   = acc_q + ACC_W'(pwr_in);
        avg_c   = IN_W'(sum_c >> LOG_WIN);
        alarm_c = avg_c > thr;
        last_c  = cnt_q == CNT_LAST;
        load_c  = 1'b0;

        if (clr) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (en) begin
            if (last_c) begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                load_c  = 1'b1;
            end else begin
                state_d = ST_ACCUM;
                acc_d   = sum_c;
                cnt_d   = cnt_q + LOG_WIN'(1);
            end
        end
    end

    // Accumulator, sample counter and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef OPM_MON_PEAK_EN
    logic [IN_W-1:0] peak_q, peak_d;

    // Running window maximum, cleared together with the accumulator.
    always_comb begin
        peak_c = (pwr_in > peak_q) ? pwr_in : peak_q;
        peak_d = peak_q;
        if (clr) begin
            peak_d = '0;
        end else if (en) begin
            peak_d = last_c ? '0 : peak_c;
        end
    end

    // Peak register.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end
`else
    assign peak_c = '0;
`endif

    opm_window_monitor_out_reg #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (load_c),
        .clr    (clr),
        .sum    (sum_c),
        .avg    (avg_c),
        .alarm  (alarm_c),
        .peak   (peak_c),
        .res_if (res_if),
        .ovf    (ovf)
    );

endmodule

// File: tb/tb_opm_window_monitor.sv
// Self-checking bench for opm_window_monitor: scoreboard of expected window results.
module tb_opm_window_monitor;
    import opm_window_monitor_pkg::*;

    localparam int unsigned IN_W    = DEF_IN_W;
    localparam int unsigned LOG_WIN = DEF_LOG_WIN;
    localparam int unsigned ACC_W   = acc_width(DEF_IN_W, DEF_LOG_WIN);
`ifdef OPM_MON_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [IN_W-1:0]  avg;
        logic             alarm;
        logic [IN_W-1:0]  peak;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en  = 1'b0;
    logic            clr = 1'b0;
    logic [IN_W-1:0] pwr_in = '0;
    logic [IN_W-1:0] thr = '0;
    logic            ovf;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    opm_window_monitor_if #(.IN_W(IN_W), .ACC_W(ACC_W)) res_if ();

    opm_window_monitor dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clr    (clr),
        .pwr_in (pwr_in),
        .thr    (thr),
        .res_if (res_if),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    function automatic void push_exp(input int unsigned sum, input int unsigned peak,
                                     input logic [IN_W-1:0] th);
        exp_t e;
        e.sum   = ACC_W'(sum);
        e.avg   = IN_W'(sum >> LOG_WIN);
        e.alarm = e.avg > th;
        e.peak  = PEAK_ON ? IN_W'(peak) : '0;
        exp_q.push_back(e);
    endfunction

    // Scoreboard: every accepted transfer is popped and compared.
    always @(negedge clk) begin
        if (rst === 1'b0 && res_if.res_valid === 1'b1 && res_if.res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_result: got sum=%0d, required no result", res_if.res_sum);
            end else begin
                mon_e = exp_q.pop_front();
                n_chk++;
                if (res_if.res_sum !== mon_e.sum)
                    $display("FAIL res_sum: got %0d, required %0d", res_if.res_sum, mon_e.sum);
                else n_pass++;
                n_chk++;
                if (res_if.res_avg !== mon_e.avg)
                    $display("FAIL res_avg: got %0d, required %0d", res_if.res_avg, mon_e.avg);
                else n_pass++;
                n_chk++;
                if (res_if.res_alarm !== mon_e.alarm)
                    $display("FAIL res_alarm: got %0b, required %0b", res_if.res_alarm, mon_e.alarm);
                else n_pass++;
                n_chk++;
                if (res_if.res_peak !== mon_e.peak)
                    $display("FAIL res_peak: got %0d, required %0d", res_if.res_peak, mon_e.peak);
                else n_pass++;
            end
        end
    end

    task automatic step(input logic e, input logic [IN_W-1:0] p);
        en     = e;
        pwr_in = p;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0)
            $display("FAIL drain_%s: got %0d pending results, required 0", name, exp_q.size());
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        res_if.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (res_if.res_valid !== 1'b0) $display("FAIL reset_valid: got %0b, required 0", res_if.res_valid); else n_pass++;
        n_chk++; if (res_if.res_sum !== '0) $display("FAIL reset_sum: got %0d, required 0", res_if.res_sum); else n_pass++;
        n_chk++; if (res_if.res_avg !== '0) $display("FAIL reset_avg: got %0d, required 0", res_if.res_avg); else n_pass++;
        n_chk++; if (res_if.res_alarm !== 1'b0) $display("FAIL reset_alarm: got %0b, required 0", res_if.res_alarm); else n_pass++;
        n_chk++; if (res_if.res_peak !== '0) $display("FAIL reset_peak: got %0d, required 0", res_if.res_peak); else n_pass++;
        n_chk++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %0b, required 0", ovf); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        thr = 10'd99;
        res_if.res_ready = 1'b1;
        push_exp(1600, 100, 10'd99);
        for (int i = 0; i < 15; i++) step(1'b1, 10'd100);
        en = 1'b1;
        pwr_in = 10'd100;
        @(negedge clk);
        n_chk++; if (res_if.res_valid !== 1'b0) $display("FAIL latency_early: got valid=%0b, required 0", res_if.res_valid); else n_pass++;
        @(posedge clk);
        #1;
        en = 1'b0;
        @(negedge clk);
        n_chk++; if (res_if.res_valid !== 1'b1) $display("FAIL latency: got valid=%0b, required 1", res_if.res_valid); else n_pass++;
        @(negedge clk);
        n_chk++; if (res_if.res_valid !== 1'b0) $display("FAIL valid_fall: got valid=%0b, required 0", res_if.res_valid); else n_pass++;
        thr = 10'd100;
        push_exp(1600, 100, 10'd100);
        for (int i = 0; i < 16; i++) step(1'b1, 10'd100);
        wait_drain("basic");
    endtask

    task automatic test_ramp();
        thr = 10'd6;
        push_exp(120, 15, 10'd6);
        for (int i = 0; i < 16; i++) step(1'b1, IN_W'(i));
        wait_drain("ramp");
    endtask

    task automatic test_backpressure();
        thr = 10'd100;
        res_if.res_ready = 1'b0;
        push_exp(800, 50, 10'd100);
        for (int i = 0; i < 16; i++) step(1'b1, 10'd50);
        @(negedge clk);
        n_chk++; if (res_if.res_valid !== 1'b1) $display("FAIL bp_held_valid: got %0b, required 1", res_if.res_valid); else n_pass++;
        n_chk++; if (ovf !== 1'b0) $display("FAIL bp_ovf_early: got %0b, required 0", ovf); else n_pass++;
        for (int i = 0; i < 16; i++) step(1'b1, 10'd50);
        @(negedge clk);
        n_chk++; if (res_if.res_valid !== 1'b1) $display("FAIL bp_still_valid: got %0b, required 1", res_if.res_valid); else n_pass++;
        n_chk++; if (res_if.res_sum !== ACC_W'(800)) $display("FAIL bp_old_sum: got %0d, required 800", res_if.res_sum); else n_pass++;
        n_chk++; if (ovf !== 1'b1) $display("FAIL bp_ovf: got %0b, required 1", ovf); else n_pass++;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        n_chk++; if (ovf !== 1'b0) $display("FAIL clr_ovf: got %0b, required 0", ovf); else n_pass++;
        n_chk++; if (res_if.res_valid !== 1'b1) $display("FAIL clr_keeps_valid: got %0b, required 1", res_if.res_valid); else n_pass++;
        n_chk++; if (res_if.res_sum !== ACC_W'(800)) $display("FAIL clr_keeps_sum: got %0d, required 800", res_if.res_sum); else n_pass++;
        @(posedge clk);
        #1;
        res_if.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (res_if.res_valid !== 1'b0) $display("FAIL bp_release: got valid=%0b, required 0", res_if.res_valid); else n_pass++;
        wait_drain("backpressure");
    endtask

    task automatic test_gap();
        thr = 10'd10;
        push_exp(376, 46, 10'd10);
        for (int i = 0; i < 8; i++) step(1'b1, IN_W'(3 * i + 1));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 10'd1023);
            @(negedge clk);
            n_chk++; if (res_if.res_valid !== 1'b0) $display("FAIL gap_idle_%0d: got valid=%0b, required 0", i, res_if.res_valid); else n_pass++;
        end
        for (int i = 8; i < 16; i++) step(1'b1, IN_W'(3 * i + 1));
        @(negedge clk);
        n_chk++; if (res_if.res_valid !== 1'b1) $display("FAIL gap_latency: got valid=%0b, required 1", res_if.res_valid); else n_pass++;
        wait_drain("gap");
    endtask

    task automatic test_clr();
        thr = 10'd25;
        for (int i = 0; i < 7; i++) step(1'b1, 10'd20);
        clr = 1'b1;
        en = 1'b1;
        pwr_in = 10'd20;
        @(posedge clk);
        #1;
        clr = 1'b0;
        en = 1'b0;
        push_exp(480, 30, 10'd25);
        for (int i = 0; i < 15; i++) step(1'b1, 10'd30);
        @(negedge clk);
        n_chk++; if (res_if.res_valid !== 1'b0) $display("FAIL clr_no_early: got valid=%0b, required 0", res_if.res_valid); else n_pass++;
        step(1'b1, 10'd30);
        @(negedge clk);
        n_chk++; if (res_if.res_valid !== 1'b1) $display("FAIL clr_result: got valid=%0b, required 1", res_if.res_valid); else n_pass++;
        n_chk++; if (ovf !== 1'b0) $display("FAIL clr_ovf_stays: got %0b, required 0", ovf); else n_pass++;
        wait_drain("clr");
    endtask

    task automatic test_max_reset();
        thr = 10'd1022;
        push_exp(16368, 1023, 10'd1022);
        for (int i = 0; i < 16; i++) step(1'b1, 10'd1023);
        wait_drain("max");
        for (int i = 0; i < 9; i++) step(1'b1, 10'd1023);
        rst = 1'b1;
        en = 1'b1;
        pwr_in = 10'd1023;
        @(posedge clk);
        #1;
        rst = 1'b0;
        en = 1'b0;
        @(negedge clk);
        n_chk++; if (res_if.res_valid !== 1'b0) $display("FAIL rst_mid_valid: got %0b, required 0", res_if.res_valid); else n_pass++;
        n_chk++; if (res_if.res_sum !== '0) $display("FAIL rst_mid_sum: got %0d, required 0", res_if.res_sum); else n_pass++;
        n_chk++; if (ovf !== 1'b0) $display("FAIL rst_mid_ovf: got %0b, required 0", ovf); else n_pass++;
        for (int i = 0; i < 20; i++) step(1'b0, 10'd0);
        thr = 10'd0;
        push_exp(80, 5, 10'd0);
        for (int i = 0; i < 15; i++) step(1'b1, 10'd5);
        @(negedge clk);
        n_chk++; if (res_if.res_valid !== 1'b0) $display("FAIL rst_cnt_early: got valid=%0b, required 0", res_if.res_valid); else n_pass++;
        step(1'b1, 10'd5);
        @(negedge clk);
        n_chk++; if (res_if.res_valid !== 1'b1) $display("FAIL rst_cnt_result: got valid=%0b, required 1", res_if.res_valid); else n_pass++;
        wait_drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ramp();
        test_backpressure();
        test_gap();
        test_clr();
        test_max_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
